// File: rtl/mac_acc_pkg.sv
// Shared types, limits and saturation helper for the
// product accumulator.
package mac_acc_pkg;

  localparam int PKG_ACC_W = 40;
  localparam int PKG_LEN_W = 8;
  localparam int PKG_OUT_W = 32;

  typedef enum logic {IDLE, ACCUM} state_e;

  localparam logic signed [PKG_OUT_W-1:0] OUT_MAX =
    {1'b0, {(PKG_OUT_W-1){1'b1}}};
  localparam logic signed [PKG_OUT_W-1:0] OUT_MIN =
    {1'b1, {(PKG_OUT_W-1){1'b0}}};

  localparam logic signed [PKG_ACC_W-1:0] ACC_HI =
    {{(PKG_ACC_W-PKG_OUT_W){1'b0}}, OUT_MAX};
  localparam logic signed [PKG_ACC_W-1:0] ACC_LO =
    {{(PKG_ACC_W-PKG_OUT_W){1'b1}}, OUT_MIN};

  typedef struct packed {
    logic                 sat;
    logic [PKG_OUT_W-1:0] sum;
  } out_t;

  function automatic out_t sat_to_out(
    input logic signed [PKG_ACC_W-1:0] acc
  );
    out_t r;
    r.sat = 1'b1;
    r.sum = OUT_MAX;
    if (acc < ACC_LO) begin
      r.sum = OUT_MIN;
    end else if (acc <= ACC_HI) begin
      r.sat = 1'b0;
      r.sum = acc[PKG_OUT_W-1:0];
    end
    return r;
  endfunction

  // sat_to_out is built at the package widths, so the
  // top parameters must match them.
  function automatic bit widths_ok(
    input int acc_w,
    input int len_w,
    input int out_w
  );
    return (acc_w >= 32 + len_w) && (out_w <= acc_w) &&
           (acc_w == PKG_ACC_W) && (out_w == PKG_OUT_W);
  endfunction

endpackage

// File: rtl/mac_acc_out_slice.sv
// One-entry valid/ready result buffer with
// simultaneous load and pop.
module mac_acc_out_slice
  import mac_acc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  out_t load_data,
  input  logic out_ready,
  output logic out_valid,
  output out_t out_data,
  output logic full,
  output logic pop
);

  logic valid_q, valid_d;
  out_t data_q, data_d;

  always_comb begin
    pop     = valid_q && out_ready;
    valid_d = load || (valid_q && !pop);
    data_d  = load ? load_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign full      = valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mac_product_accumulator.sv
// Accumulates signed MAC products into saturated
// per-vector dot-product sums.
module mac_product_accumulator
  import mac_acc_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [LEN_W-1:0] CFG_LEN,
  input  logic             IN_VALID,
  input  logic [31:0]      IN_PROD,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT_SUM,
  output logic             OUT_SAT,
  output logic             BUSY
);

  if (!widths_ok(ACC_W, LEN_W, OUT_W)) begin : g_width_err
    $error("mac_product_accumulator: bad ACC_W/OUT_W");
  end

  localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] MAX_LEN = {1'b1, {LEN_W{1'b0}}};

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic [LEN_W:0]          cnt_q, cnt_d, len_q, len_d;
  logic [LEN_W:0]          first_len, cnt_inc;
  logic                    final_beat, beat, load;
  logic                    full, pop;
  out_t                    res, held;

  always_comb begin
    first_len  = (CFG_LEN == '0) ? MAX_LEN : {1'b0, CFG_LEN};
    cnt_inc    = cnt_q + ONE;
    final_beat = (state_q == IDLE) ? (first_len == ONE)
                                   : (cnt_inc == len_q);
    // Only a final beat needs buffer room; a pop this
    // cycle frees it in time.
    IN_READY   = !(full && !pop && final_beat);
    beat       = IN_VALID && IN_READY;
    load       = beat && final_beat;
    sum        = acc_q + {{(ACC_W-32){IN_PROD[31]}}, IN_PROD};
    res        = sat_to_out(sum);
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    if (beat) begin
      if (final_beat) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum;
        cnt_d   = cnt_inc;
        if (state_q == IDLE) len_d = first_len;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  mac_acc_out_slice u_out (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .load_data (res),
    .out_ready (OUT_READY),
    .out_valid (OUT_VALID),
    .out_data  (held),
    .full      (full),
    .pop       (pop)
  );

  assign OUT_SUM = held.sum;
  assign OUT_SAT = held.sat;
  assign BUSY    = (state_q == ACCUM);

endmodule

// File: tb/tb_mac_product_accumulator.sv
// Directed table-driven bench for the product
// accumulator.
module tb_mac_product_accumulator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  CFG_LEN = 8'd0;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_PROD = 32'd0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] OUT_SUM;
  logic        OUT_SAT;
  logic        BUSY;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  mac_product_accumulator #(
    .ACC_W (40),
    .LEN_W (8),
    .OUT_W (32)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CFG_LEN   (CFG_LEN),
    .IN_VALID  (IN_VALID),
    .IN_PROD   (IN_PROD),
    .IN_READY  (IN_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_SUM   (OUT_SUM),
    .OUT_SAT   (OUT_SAT),
    .BUSY      (BUSY)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  len;
    logic        v;
    logic [31:0] p;
    logic        ordy;
    logic        rdy;
    logic        ov;
    logic [31:0] sum;
    logic        sat;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] len,
                     input logic v, input logic [31:0] p,
                     input logic ordy, input logic rdy,
                     input logic ov, input logic [31:0] sum,
                     input logic sat, input logic busy);
    vec_t r;
    r.rst = rst; r.len = len; r.v = v; r.p = p; r.ordy = ordy;
    r.rdy = rdy; r.ov = ov; r.sum = sum; r.sat = sat;
    r.busy = busy;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic rst, input logic [7:0] len,
                       input logic v, input logic [31:0] p,
                       input logic ordy);
    @(negedge CLK);
    RST = rst;
    CFG_LEN = len;
    IN_VALID = v;
    IN_PROD = p;
    OUT_READY = ordy;
    #1;
  endtask

  initial begin
    // rst len v prod ordy | rdy ov sum sat busy
    add(1, 0, 0, 0, 1,            1, 0, 0, 0, 0);
    add(0, 4, 1, 1, 1,            1, 0, 0, 0, 1);
    add(0, 4, 1, 2, 1,            1, 0, 0, 0, 1);
    add(0, 4, 1, 3, 1,            1, 0, 0, 0, 1);
    add(0, 4, 1, 4, 1,            1, 1, 10, 0, 0);
    add(0, 4, 0, 0, 1,            1, 0, 10, 0, 0);
    add(0, 2, 1, 32'h8000_0000, 1, 1, 0, 10, 0, 1);
    add(0, 2, 1, 32'h8000_0000, 1, 1, 1, 32'h8000_0000, 1, 0);
    add(0, 2, 1, 32'h7FFF_FFFF, 1, 1, 0, 32'h8000_0000, 1, 1);
    add(0, 2, 1, 32'h7FFF_FFFF, 1, 1, 1, 32'h7FFF_FFFF, 1, 0);
    add(0, 1, 0, 0, 1,            1, 0, 32'h7FFF_FFFF, 1, 0);
    add(0, 1, 1, 5, 0,            1, 1, 5, 0, 0);
    add(0, 1, 1, 7, 0,            0, 1, 5, 0, 0);
    add(0, 1, 1, 7, 0,            0, 1, 5, 0, 0);
    add(0, 1, 1, 7, 1,            1, 1, 7, 0, 0);
    add(0, 1, 0, 0, 1,            1, 0, 7, 0, 0);
    add(0, 4, 1, 9, 1,            1, 0, 7, 0, 1);
    add(0, 4, 1, 9, 1,            1, 0, 7, 0, 1);
    add(1, 4, 0, 0, 1,            1, 0, 0, 0, 0);
    add(0, 4, 1, 1, 1,            1, 0, 0, 0, 1);
    add(0, 4, 1, 1, 1,            1, 0, 0, 0, 1);
    add(0, 4, 1, 1, 1,            1, 0, 0, 0, 1);
    add(0, 4, 1, 1, 1,            1, 1, 4, 0, 0);
    add(0, 3, 1, 1, 1,            1, 0, 4, 0, 1);
    add(0, 2, 1, 1, 1,            1, 0, 4, 0, 1);
    add(0, 2, 1, 1, 1,            1, 1, 3, 0, 0);
    add(0, 2, 1, 2, 1,            1, 0, 3, 0, 1);
    add(0, 2, 1, 2, 1,            1, 1, 4, 0, 0);
    add(0, 2, 1, 32'hFFFF_FFFD, 1, 1, 0, 4, 0, 1);
    add(0, 2, 1, 1, 1,            1, 1, 32'hFFFF_FFFE, 0, 0);
    add(0, 2, 0, 0, 1,            1, 0, 32'hFFFF_FFFE, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].len, vecs[i].v, vecs[i].p,
            vecs[i].ordy);
      chk($sformatf("row%0d in_ready", i), {31'd0, IN_READY},
          {31'd0, vecs[i].rdy});
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d out_valid", i), {31'd0, OUT_VALID},
          {31'd0, vecs[i].ov});
      chk($sformatf("row%0d out_sum", i), OUT_SUM, vecs[i].sum);
      chk($sformatf("row%0d out_sat", i), {31'd0, OUT_SAT},
          {31'd0, vecs[i].sat});
      chk($sformatf("row%0d busy", i), {31'd0, BUSY},
          {31'd0, vecs[i].busy});
    end

    // CFG_LEN = 0 means a 256-beat vector.
    for (int i = 1; i <= 256; i++) begin
      drive(0, 8'd0, 1, 32'd1, 1);
      chk($sformatf("len256 beat%0d in_ready", i),
          {31'd0, IN_READY}, 32'd1);
      @(posedge CLK);
      #1;
      if (i < 256) begin
        chk($sformatf("len256 beat%0d busy", i),
            {31'd0, BUSY}, 32'd1);
        chk($sformatf("len256 beat%0d out_valid", i),
            {31'd0, OUT_VALID}, 32'd0);
      end else begin
        chk("len256 out_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("len256 out_sum", OUT_SUM, 32'd256);
        chk("len256 out_sat", {31'd0, OUT_SAT}, 32'd0);
        chk("len256 busy_end", {31'd0, BUSY}, 32'd0);
      end
    end
    drive(0, 8'd0, 0, 32'd0, 1);
    @(posedge CLK);
    #1;
    chk("len256 drained", {31'd0, OUT_VALID}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
